// File: rtl/uart_line_responder.sv
// Line-editing terminal responder on the user side of the UART FIFOs.
// Echoes input, handles backspace, and replays the line upper-cased on CR.
module uart_line_responder #(
    parameter int DBIT   = 8,
    parameter int LINE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DBIT-1:0]   r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [DBIT-1:0]   w_data,
    output logic              wr_uart,
    output logic [LINE_W:0]   line_len,
    output logic              busy,
    output logic              ovf_tick
);

    localparam int              DEPTH = 2 ** LINE_W;
    localparam logic [LINE_W:0] FULL  = (LINE_W + 1)'(DEPTH);
    localparam logic [DBIT-1:0] C_BEL = DBIT'(8'h07);
    localparam logic [DBIT-1:0] C_BS  = DBIT'(8'h08);
    localparam logic [DBIT-1:0] C_LF  = DBIT'(8'h0A);
    localparam logic [DBIT-1:0] C_CR  = DBIT'(8'h0D);
    localparam logic [DBIT-1:0] C_SP  = DBIT'(8'h20);
    localparam logic [DBIT-1:0] C_TL  = DBIT'(8'h7E);
    localparam logic [DBIT-1:0] C_LA  = DBIT'(8'h61);
    localparam logic [DBIT-1:0] C_LZ  = DBIT'(8'h7A);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, ECHO, NL1, NL2, DUMP, END1, END2
    } state_t;

    state_t                 state_q, state_d;
    logic [DBIT-1:0]        ch_q, ch_d;
    logic [LINE_W:0]        len_q, len_d;
    logic [LINE_W-1:0]      idx_q, idx_d;
    logic [3:0][DBIT-1:0]   eq_q, eq_d;
    logic [1:0]             elast_q, elast_d;
    logic [1:0]             eidx_q, eidx_d;
    logic [DBIT-1:0]        mem_q [DEPTH];

    logic                   we;
    logic                   rd, wr, ovf;
    logic [DBIT-1:0]        wd;

    function automatic logic [DBIT-1:0] upcase(input logic [DBIT-1:0] b);
        return (b >= C_LA && b <= C_LZ) ? b - C_SP : b;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            eq_q    <= '0;
            elast_q <= '0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            elast_q <= elast_d;
            eidx_q  <= eidx_d;
        end
    end

    // Write slot is always len_q, which is below DEPTH whenever we is set.
    always_ff @(posedge clk) begin
        if (we) mem_q[len_q[LINE_W-1:0]] <= ch_q;
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        len_d   = len_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        elast_d = elast_q;
        eidx_d  = eidx_q;
        we      = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        ovf     = 1'b0;
        wd      = '0;
        unique case (state_q)
            IDLE: begin
                if (!rx_empty) begin
                    rd      = 1'b1;
                    ch_d    = r_data;
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                eidx_d  = '0;
                elast_d = '0;
                state_d = ECHO;
                if (ch_q >= C_SP && ch_q <= C_TL) begin
                    if (len_q < FULL) begin
                        we      = 1'b1;
                        len_d   = len_q + 1'b1;
                        eq_d[0] = ch_q;
                    end else begin
                        ovf     = 1'b1;
                        eq_d[0] = C_BEL;
                    end
                end else if (ch_q == C_BS) begin
                    if (len_q != '0) begin
                        len_d   = len_q - 1'b1;
                        eq_d[0] = C_BS;
                        eq_d[1] = C_SP;
                        eq_d[2] = C_BS;
                        elast_d = 2'd2;
                    end else begin
                        eq_d[0] = C_BEL;
                    end
                end else if (ch_q == C_CR) begin
                    state_d = NL1;
                end else begin
                    state_d = IDLE;
                end
            end
            ECHO: begin
                if (!tx_full) begin
                    wr = 1'b1;
                    wd = eq_q[eidx_q];
                    if (eidx_q == elast_q) state_d = IDLE;
                    else eidx_d = eidx_q + 1'b1;
                end
            end
            NL1: begin
                if (!tx_full) begin
                    wr      = 1'b1;
                    wd      = C_CR;
                    state_d = NL2;
                end
            end
            NL2: begin
                if (!tx_full) begin
                    wr    = 1'b1;
                    wd    = C_LF;
                    idx_d = '0;
                    state_d = (len_q == '0) ? IDLE : DUMP;
                end
            end
            DUMP: begin
                if (!tx_full) begin
                    wr = 1'b1;
                    wd = upcase(mem_q[idx_q]);
                    if ({1'b0, idx_q} == len_q - 1'b1) state_d = END1;
                    else idx_d = idx_q + 1'b1;
                end
            end
            END1: begin
                if (!tx_full) begin
                    wr      = 1'b1;
                    wd      = C_CR;
                    state_d = END2;
                end
            end
            END2: begin
                if (!tx_full) begin
                    wr      = 1'b1;
                    wd      = C_LF;
                    len_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are held quiet while reset is asserted.
    assign rd_uart  = rd & reset;
    assign wr_uart  = wr & reset;
    assign ovf_tick = ovf & reset;
    assign w_data   = reset ? wd : '0;
    assign line_len = reset ? len_q : '0;
    assign busy     = reset && (state_q != IDLE);

endmodule

// File: tb/tb_uart_line_responder.sv
// Directed bench for uart_line_responder: drives a model RX FIFO and
// records every byte pushed to the TX side.
module tb_uart_line_responder;

    typedef logic [7:0] u8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [4:0] line_len;
    logic       busy;
    logic       ovf_tick;

    int checks = 0;
    int errors = 0;

    u8  rxq[$];
    u8  txq[$];
    int rd_cnt = 0;
    int ovf_cnt = 0;
    int wr_full = 0;

    uart_line_responder #(.DBIT(8), .LINE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .line_len (line_len),
        .busy     (busy),
        .ovf_tick (ovf_tick)
    );

    always #5 clk = ~clk;

    task automatic clear_log();
        txq.delete();
        rd_cnt  = 0;
        ovf_cnt = 0;
        wr_full = 0;
    endtask

    // One clock: present FIFO head, sample at negedge, commit pop after posedge.
    task automatic step();
        logic s_rd;
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
        @(negedge clk);
        s_rd = rd_uart;
        if (rd_uart) rd_cnt++;
        if (ovf_tick) ovf_cnt++;
        if (wr_uart && tx_full) wr_full++;
        if (wr_uart) txq.push_back(w_data);
        @(posedge clk);
        #1;
        if (s_rd && rxq.size() != 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic drain(input int max, output bit ok);
        int n = 0;
        while ((rxq.size() != 0 || busy) && n < max) begin
            step();
            n++;
        end
        ok = (rxq.size() == 0 && !busy);
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_empty = 1'b0;
        r_data   = 8'h41;
        @(negedge clk);
        checks++;
        if ({rd_uart, wr_uart, busy, ovf_tick} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got rd/wr/busy/ovf=%b want 0000",
                     {rd_uart, wr_uart, busy, ovf_tick});
        end
        checks++;
        if (w_data !== 8'h00 || line_len !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got w_data=%h len=%0d want 00/0",
                     w_data, line_len);
        end
        @(posedge clk);
        #1;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        reset    = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || rd_cnt !== 0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b rd=%0d want 0/0", busy, rd_cnt);
        end
    endtask

    task automatic test_hi();
        u8  exp[$] = '{8'h68, 8'h69, 8'h0D, 8'h0A, 8'h48, 8'h49, 8'h0D, 8'h0A};
        bit ok;
        int mi = -1;
        clear_log();
        rxq = '{8'h68, 8'h69, 8'h0D};
        drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hi_timeout got busy=%b want 0", busy); end
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (mi >= 0 || txq.size() != exp.size()) begin
            errors++;
            $display("FAIL hi_stream got %0d bytes (first bad idx %0d) want %0d",
                     txq.size(), mi, exp.size());
        end
        checks++;
        if (rd_cnt !== 3 || line_len !== 5'd0) begin
            errors++;
            $display("FAIL hi_counts got rd=%0d len=%0d want 3/0", rd_cnt, line_len);
        end
    endtask

    task automatic test_backspace();
        u8  exp[$] = '{8'h61, 8'h62, 8'h08, 8'h20, 8'h08, 8'h63,
                       8'h0D, 8'h0A, 8'h41, 8'h43, 8'h0D, 8'h0A};
        bit ok;
        int mi = -1;
        clear_log();
        rxq = '{8'h61, 8'h62, 8'h08, 8'h63, 8'h0D};
        drain(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bs_timeout got busy=%b want 0", busy); end
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (mi >= 0 || txq.size() != exp.size()) begin
            errors++;
            $display("FAIL bs_stream got %0d bytes (first bad idx %0d) want %0d",
                     txq.size(), mi, exp.size());
        end
    endtask

    task automatic test_overflow();
        u8  exp[$];
        bit ok;
        int mi = -1;
        clear_log();
        for (int k = 0; k < 17; k++) rxq.push_back(8'h78);
        for (int k = 0; k < 16; k++) exp.push_back(8'h78);
        exp.push_back(8'h07);
        drain(500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ovf_timeout got busy=%b want 0", busy); end
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (mi >= 0 || txq.size() != exp.size()) begin
            errors++;
            $display("FAIL ovf_stream got %0d bytes (first bad idx %0d) want %0d",
                     txq.size(), mi, exp.size());
        end
        checks++;
        if (ovf_cnt !== 1 || line_len !== 5'd16) begin
            errors++;
            $display("FAIL ovf_counts got ovf=%0d len=%0d want 1/16", ovf_cnt, line_len);
        end
        clear_log();
        exp = '{8'h0D, 8'h0A};
        for (int k = 0; k < 16; k++) exp.push_back(8'h58);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        rxq = '{8'h0D};
        drain(300, ok);
        mi = -1;
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (!ok || mi >= 0 || txq.size() != exp.size() || line_len !== 5'd0) begin
            errors++;
            $display("FAIL full_dump got %0d bytes (first bad idx %0d) len=%0d want %0d/0",
                     txq.size(), mi, line_len, exp.size());
        end
    endtask

    task automatic test_empty_line();
        bit ok;
        clear_log();
        rxq = '{8'h0D};
        drain(100, ok);
        checks++;
        if (!ok || txq.size() != 2 || txq[0] !== 8'h0D || txq[1] !== 8'h0A) begin
            errors++;
            $display("FAIL empty_cr got %0d bytes want 2 (0D 0A)", txq.size());
        end
        clear_log();
        rxq = '{8'h08};
        drain(100, ok);
        checks++;
        if (!ok || txq.size() != 1 || txq[0] !== 8'h07) begin
            errors++;
            $display("FAIL empty_bs got %0d bytes want 1 (07)", txq.size());
        end
        clear_log();
        rxq = '{8'h0A, 8'h01};
        drain(100, ok);
        checks++;
        if (!ok || txq.size() != 0 || rd_cnt !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored got tx=%0d rd=%0d busy=%b want 0/2/0",
                     txq.size(), rd_cnt, busy);
        end
    endtask

    task automatic test_stall();
        u8  exp[$] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A,
                       8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
        bit ok;
        int n = 0;
        int mi = -1;
        int wr_seen = 0;
        clear_log();
        rxq = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D};
        while (txq.size() < 9 && n < 300) begin
            step();
            n++;
        end
        tx_full = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (wr_uart) wr_seen++;
        end
        checks++;
        if (txq.size() != 9 || wr_full != 0 || wr_seen != 0) begin
            errors++;
            $display("FAIL stall_hold got tx=%0d wr_full=%0d want 9/0",
                     txq.size(), wr_full + wr_seen);
        end
        tx_full = 1'b0;
        drain(300, ok);
        checks++;
        if (txq.size() < 10 || txq[9] !== 8'h4C) begin
            errors++;
            $display("FAIL stall_resume got %h want 4c",
                     (txq.size() > 9) ? txq[9] : 8'hXX);
        end
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (!ok || mi >= 0 || txq.size() != exp.size()) begin
            errors++;
            $display("FAIL stall_stream got %0d bytes (first bad idx %0d) want %0d",
                     txq.size(), mi, exp.size());
        end
    endtask

    task automatic test_reset_mid_dump();
        u8  exp[$] = '{8'h61, 8'h0D, 8'h0A, 8'h41, 8'h0D, 8'h0A};
        bit ok;
        int n = 0;
        int mi = -1;
        clear_log();
        rxq = '{8'h61, 8'h62, 8'h63, 8'h0D};
        while (txq.size() < 6 && n < 300) begin
            step();
            n++;
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (wr_uart !== 1'b0 || busy !== 1'b0 || line_len !== 5'd0 || txq.size() != 6) begin
            errors++;
            $display("FAIL mid_reset got wr=%b busy=%b len=%0d tx=%0d want 0/0/0/6",
                     wr_uart, busy, line_len, txq.size());
        end
        clear_log();
        rxq = '{8'h61, 8'h0D};
        drain(200, ok);
        foreach (exp[k]) if (mi < 0 && (k >= txq.size() || txq[k] !== exp[k])) mi = k;
        checks++;
        if (!ok || mi >= 0 || txq.size() != exp.size()) begin
            errors++;
            $display("FAIL post_reset got %0d bytes (first bad idx %0d) want %0d",
                     txq.size(), mi, exp.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_hi();
        test_backspace();
        test_overflow();
        test_empty_line();
        test_stall();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
